// File: rtl/vadd_pipe.sv
// vadd_pipe: pipelined N-lane signed vector adder with a valid/ready stream.
// Each lane can add with wrap, subtract with wrap, add with saturation, or
// accumulate into a per-lane register. The result of an accepted beat is
// computed on entry to stage 1. Later stages only delay {valid, y, ovf}.
// A global enable freezes every register in the block.
module vadd_pipe #(
  parameter int LANES  = 4,
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic                   acc_clr,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] y,
  output logic [LANES-1:0]       ovf
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_SAT = 2'b10,
    MODE_ACC = 2'b11
  } mode_t;

  localparam int VW = LANES * WIDTH;

  // Clamp limits for saturating add: most negative and most positive lane value.
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  mode_t op;
  assign op = mode_t'(mode);

  // Handshake. The pipeline moves only as a whole. It stalls when the output
  // holds a beat the sink refuses, or when the block is disabled.
  logic advance;
  logic accept;
  logic acc_beat;

  assign advance  = en && (!out_valid || out_ready);
  assign in_ready = advance && reset;
  assign accept   = in_valid && in_ready;
  assign acc_beat = accept && (op == MODE_ACC);

  logic [VW-1:0]    comp_y;
  logic [LANES-1:0] comp_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0] lane_a;
    logic signed [WIDTH-1:0] lane_b;
    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] acc_src;
    logic signed [WIDTH-1:0] lane_y;
    logic        [WIDTH:0]   raw;
    logic                    lane_ovf;

    assign lane_a = a[i*WIDTH +: WIDTH];
    assign lane_b = b[i*WIDTH +: WIDTH];

    // A clear in the same cycle as an accumulate beat makes that beat start from zero.
    assign acc_src = acc_clr ? '0 : acc_q;

    // Lane arithmetic at WIDTH+1 bits. Overflow shows as a disagreement
    // between the two top bits of the widened result.
    always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      raw      = '0;
      lane_y   = '0;
      lane_ovf = 1'b0;
      case (op)
        MODE_ADD, MODE_SAT: raw = {lane_a[WIDTH-1], lane_a} + {lane_b[WIDTH-1], lane_b};
        MODE_SUB:           raw = {lane_a[WIDTH-1], lane_a} - {lane_b[WIDTH-1], lane_b};
        MODE_ACC:           raw = {acc_src[WIDTH-1], acc_src} + {lane_a[WIDTH-1], lane_a};
        default:            raw = '0;
      endcase
      lane_ovf = raw[WIDTH] ^ raw[WIDTH-1];
      lane_y   = raw[WIDTH-1:0];
      if (op == MODE_SAT && lane_ovf) begin
        lane_y = raw[WIDTH] ? SAT_MIN : SAT_MAX;
      end
    end

    assign comp_y[i*WIDTH +: WIDTH] = lane_y;
    assign comp_ovf[i]              = lane_ovf;

    // Accumulator. It loads the result of accepted accumulate beats and honours a
    // standalone clear whenever the block is enabled.
    always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments, so every flop
      // samples values from before the edge, whatever the statement order.
      if (!reset) begin
        acc_q <= '0;
      end else if (acc_beat) begin
        acc_q <= lane_y;
      end else if (en && acc_clr) begin
        acc_q <= '0;
      end
    end
  end

  // Pipeline stage storage. Index 0 is loaded at acceptance, index STAGES-1 drives the outputs.
  logic [STAGES-1:0] stg_valid;
  logic [VW-1:0]     stg_y   [STAGES];
  logic [LANES-1:0]  stg_ovf [STAGES];

  // Stage shift register. Bubbles move through the pipeline as zeros, and reset empties every stage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stg_valid <= '0;
      // NOTE: the stage arrays are reset element by element. In-flight data
      // must vanish on reset, and y must read 0 afterwards.
      for (int s = 0; s < STAGES; s++) begin
        stg_y[s]   <= '0;
        stg_ovf[s] <= '0;
      end
    end else if (advance) begin
      stg_valid[0] <= accept;
      stg_y[0]     <= accept ? comp_y : '0;
      stg_ovf[0]   <= accept ? comp_ovf : '0;
      for (int s = 1; s < STAGES; s++) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_y[s]     <= stg_y[s-1];
        stg_ovf[s]   <= stg_ovf[s-1];
      end
    end
  end

  assign out_valid = stg_valid[STAGES-1];
  assign y         = stg_y[STAGES-1];
  assign ovf       = stg_ovf[STAGES-1];

endmodule

// File: doc/vadd_pipe.md
# vadd_pipe

Parametrised, pipelined N-lane signed vector adder with a valid/ready stream interface. It generalises the fixed 4-lane, 8-bit lane adder to configurable lane count, lane width and pipeline depth. It adds subtract, saturating-add and per-lane accumulate modes, plus per-lane overflow flags. It sits between a vector operand source and a result sink in the datapath, with a global enable that freezes the whole block.

## Interface
- LANES, 4, number of independent lanes (1..16)
- WIDTH, 8, signed lane width in bits (4..32)
- STAGES, 2, pipeline depth in register stages (1..4); latency from accept to out_valid
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- en  in  1  global enable; 0 freezes every register, including the accumulators
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat accepted when in_valid && in_ready
- mode  in  2  per-beat operation: 00 add-wrap, 01 sub-wrap, 10 add-saturate, 11 accumulate
- acc_clr  in  1  clear all lane accumulators
- a  in  LANES*WIDTH  operand A; lane i is bits [i*WIDTH +: WIDTH]
- b  in  LANES*WIDTH  operand B; ignored in accumulate mode
- out_valid  out  1  result beat valid
- out_ready  in  1  sink accepts result
- y  out  LANES*WIDTH  per-lane signed result
- ovf  out  LANES  per-lane overflow/clamp flag for the current result beat

## Operation
- advance = en && (!out_valid || out_ready). All pipeline stages shift together on advance. Bubbles are carried, not collapsed.
- in_ready = advance && reset. It is combinational and is 0 while reset is low.
- Computation happens at acceptance into stage 1. Stages 2..STAGES are pure delay of {valid, y, ovf}.
- Per-lane arithmetic is signed WIDTH-bit, computed internally at WIDTH+1 bits.
  - 00: y = a+b, truncated. ovf = signed overflow.
  - 01: y = a-b, truncated. ovf = signed overflow.
  - 10: y = a+b, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. ovf = 1 when clamped.
  - 11: y = acc+a, wrap. ovf = signed overflow. acc is set to y.
- Each lane has one WIDTH-bit accumulator. It updates only on an accepted mode-11 beat.
- acc_clr takes effect when en=1, whether or not a beat is accepted.
  - acc_clr alone: acc is 0 next cycle.
  - acc_clr together with an accepted mode-11 beat: the beat uses acc=0, so y=a, and acc is set to a.
- Non-accumulate beats never modify acc.
- Lanes are fully independent. There is no carry between lanes.

## Timing
- Reset (synchronous, reset=0 at a posedge): all stage valid bits, y, ovf and acc are set to 0.
  - out_valid=0, y=0, ovf=0 the cycle after.
  - In-flight beats are discarded. There is no partial output.
- Reset has priority over en.
- Latency is STAGES cycles. A beat accepted at edge k shows out_valid=1 after edge k+STAGES-1, assuming no stall.
- Throughput is 1 beat/cycle when out_ready=1 and en=1.
- While out_valid && !out_ready: y, ovf and out_valid hold stable, and in_ready=0.
- While en=0: all state holds, in_ready=0, and outputs are stable.
- A beat is retired on out_valid && out_ready at a posedge. In the same cycle a new beat may be accepted.

## Test plan
- Defaults, mode 00, a={7,8,28,-3}, b={3,15,1,8} (lane3..lane0), in_valid=1, out_ready=1 -> after STAGES cycles, y={10,23,29,5}, ovf=0, one result per cycle.
- Mode 10, lane0 100+100 and lane1 -100+-100; mode 00 with the same operands -> saturate gives 127/-128 with ovf=1. Wrap gives -56/56 with ovf=1.
- Mode 01, lane0 -128-1 -> y=127, ovf=1. Lane1 5-9 -> y=-4, ovf=0.
- Mode 11, lane0 a=5 for three beats -> y=5, 10, 15. Then acc_clr together with a=2 -> y=2. Then a=2 -> y=4.
- Backpressure: out_ready=0 for 3 cycles while streaming -> in_ready=0, y held constant. After release, no beat is lost or duplicated and order is preserved. Repeat the check with en=0 for 2 cycles.
- Reset mid-stream with STAGES=3 and two beats in flight -> the next cycle shows out_valid=0, y=0, ovf=0. The accumulator reads 0 on the first mode-11 beat after reset.
